memory_multi_port: RTL and testbench

- Parametrised successor to the single-channel word memory.
- One byte-strobed write channel and NUM_READ_PORTS independent read channels share one single-ported word array.
- Per-cycle arbitration selects at most one access; writes take priority over reads.
- Sits behind the core's fetch, load and store paths as the unified on-chip RAM.

---
 rtl/memory_multi_port.sv | 135 +++++++++++++
 tb/tb_memory_multi_port.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_multi_port.sv
// Unified on-chip word RAM: one byte-strobed write channel, NUM_READ_PORTS read channels, one access per cycle.
// Define MEMORY_MULTI_PORT_ROUND_ROBIN_EN for a round-robin read arbiter (default: fixed priority, port 0 highest).
module memory_multi_port_rd_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        ready_o
);
  logic [31:0] data_q;
  logic        ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= gnt_i;
      if (gnt_i) data_q <= rdata_i;
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
endmodule

module memory_multi_port #(
  parameter int MEM_BIT_WIDTH  = 16,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 in_addr,
  input  logic [31:0]                 in_data,
  input  logic [3:0]                  in_strb,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [32*NUM_READ_PORTS-1:0] out_addr,
  input  logic [NUM_READ_PORTS-1:0]   out_valid,
  output logic [32*NUM_READ_PORTS-1:0] out_data,
  output logic [NUM_READ_PORTS-1:0]   out_ready
);
  localparam int DEPTH = 2**MEM_BIT_WIDTH;
  localparam int PW    = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;

  logic [31:0]                      mem_q [DEPTH];
  logic                             in_ready_q;
  logic [NUM_READ_PORTS-1:0][31:0]  raddr;
  logic [NUM_READ_PORTS-1:0]        rd_elig;
  logic [NUM_READ_PORTS-1:0]        rd_gnt;
  logic                             wr_elig;
  logic                             rd_any;
  logic                             rd_gnt_vld;
  logic [PW-1:0]                    gnt_idx;
  logic [PW-1:0]                    cand;
  logic [MEM_BIT_WIDTH-1:0]         widx;
  logic [MEM_BIT_WIDTH-1:0]         ridx;
  logic [31:0]                      rd_word;
  logic                             unused_addr_bits;

  // A pending ready masks its own channel, capping every requester at one transaction per 2 cycles.
  assign wr_elig = in_valid && !in_ready_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
      assign raddr[gi]   = out_addr[32*gi +: 32];
      assign rd_elig[gi] = out_valid[gi] && !out_ready[gi];
      assign rd_gnt[gi]  = rd_gnt_vld && (gnt_idx == PW'(gi));
      memory_multi_port_rd_lane u_lane (
        .clk     (clk),
        .reset   (reset),
        .gnt_i   (rd_gnt[gi]),
        .rdata_i (rd_word),
        .data_o  (out_data[32*gi +: 32]),
        .ready_o (out_ready[gi])
      );
    end
  endgenerate

`ifdef MEMORY_MULTI_PORT_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q;

  always_comb begin
    rd_any  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_READ_PORTS; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_READ_PORTS);
      if (!rd_any && rd_elig[cand]) begin
        rd_any  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          ptr_q <= PW'(NUM_READ_PORTS-1);
    else if (rd_gnt_vld) ptr_q <= gnt_idx;
  end
`else
  always_comb begin
    rd_any  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_READ_PORTS-1; i >= 0; i--) begin
      if (rd_elig[i]) begin
        rd_any  = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
`endif

  assign rd_gnt_vld = rd_any && !wr_elig;
  assign widx       = in_addr[MEM_BIT_WIDTH+1:2];
  assign ridx       = raddr[gnt_idx][MEM_BIT_WIDTH+1:2];
  assign rd_word    = mem_q[ridx];
  assign unused_addr_bits = ^{in_addr, out_addr};

  always_ff @(posedge clk) begin
    if (wr_elig) begin
      for (int b = 0; b < 4; b++)
        if (in_strb[b]) mem_q[widx][8*b +: 8] <= in_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_ready_q <= 1'b0;
    else        in_ready_q <= wr_elig;
  end

  assign in_ready = in_ready_q;
endmodule

// File: tb/tb_memory_multi_port.sv
// Bench for memory_multi_port: directed scenarios plus randomized traffic against a word-array model.
module tb_memory_multi_port;
  localparam int MBW   = 4;
  localparam int NRP   = 2;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        in_addr, in_data;
  logic [3:0]         in_strb;
  logic               in_valid;
  logic               in_ready;
  logic [32*NRP-1:0]  out_addr;
  logic [NRP-1:0]     out_valid;
  logic [32*NRP-1:0]  out_data;
  logic [NRP-1:0]     out_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [DEPTH];

  memory_multi_port #(.MEM_BIT_WIDTH(MBW), .NUM_READ_PORTS(NRP)) dut (
    .clk(clk), .reset(reset),
    .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_addr(out_addr), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[MBW+1:2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_strb   = '0;
    out_valid = '0;
    out_addr  = '0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    in_addr = a; in_data = d; in_strb = s; in_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (in_ready === 1'b1) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (ok) mdl[widx(a)] = merge(mdl[widx(a)], d, s);
  endtask

  task automatic do_read(input int p, input logic [31:0] a, output logic [31:0] d, output bit ok);
    out_addr[32*p +: 32] = a; out_valid[p] = 1'b1; ok = 1'b0; d = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (out_ready[p] === 1'b1) begin
        ok = 1'b1;
        d  = out_data[32*p +: 32];
      end
    end
    out_valid[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if ({in_ready, out_ready, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_por: got ready=%b/%b data=%h expected all zero", in_ready, out_ready, out_data);
    end
    tick();
    reset = 1'b1;
    mdl[5] = 32'hCAFEF00D;
    in_addr = 32'h14; in_data = 32'hCAFEF00D; in_strb = 4'hF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_in_ready: got %b expected 0", in_ready);
    end
    tick();
    reset = 1'b1;
    out_addr[63:32] = 32'h14; out_valid = 2'b10;
    tick();
    checks++;
    if (out_ready !== 2'b10 || out_data[63:32] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_prefill_read: got ready=%b data=%h expected 10/cafef00d", out_ready, out_data[63:32]);
    end
    out_valid = '0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_ready, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_async_out: got ready=%b/%b data=%h expected all zero", in_ready, out_ready, out_data);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic init_mem();
    bit ok;
    for (int w = 0; w < DEPTH; w++) begin
      do_write(32'(w*4), $urandom, 4'hF, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL init_write: word %0d got no in_ready expected pulse", w);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    in_addr = 32'h10; in_data = 32'hDEADBEEF; in_strb = 4'hF; in_valid = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency: got in_ready=%b expected 1", in_ready);
    end
    mdl[4] = 32'hDEADBEEF;
    in_valid = 1'b0;
    out_addr[31:0] = 32'h10; out_valid = 2'b01;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_ready !== 2'b01 || out_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_after_wr: got in_ready=%b out_ready=%b data=%h expected 0/01/deadbeef",
               in_ready, out_ready, out_data[31:0]);
    end
    out_valid = '0;
    tick();
    checks++;
    if (out_ready !== 2'b00 || out_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_pulse_width: got out_ready=%b data=%h expected 00/deadbeef", out_ready, out_data[31:0]);
    end
  endtask

  task automatic test_strobe();
    bit ok1, ok2, ok3;
    logic [31:0] d;
    do_write(32'h0, 32'h11223344, 4'hF, ok1);
    do_write(32'h0, 32'hAABBCCDD, 4'h5, ok2);
    do_read(1, 32'h0, d, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3) || d !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_merge: got %h (ok=%b%b%b) expected 11bb33dd", d, ok1, ok2, ok3);
    end
    do_write(32'h0, 32'h11223344, 4'hF, ok1);
    do_write(32'h0, 32'hAABBCCDD, 4'h0, ok2);
    checks++;
    if (!ok2) begin
      errors++;
      $display("FAIL strobe_zero_ack: got no in_ready expected pulse");
    end
    do_read(0, 32'h0, d, ok3);
    checks++;
    if (!ok3 || d !== 32'h11223344) begin
      errors++;
      $display("FAIL strobe_zero_data: got %h expected 11223344", d);
    end
  endtask

  task automatic test_alias();
    bit ok, ok_a, ok_b;
    logic [31:0] da, db;
    do_write(32'h40, 32'h55, 4'hF, ok);
    do_read(0, 32'h00, da, ok_a);
    do_read(1, 32'h03, db, ok_b);
    checks++;
    if (!(ok && ok_a && ok_b) || da !== 32'h55 || db !== 32'h55) begin
      errors++;
      $display("FAIL alias: got %h/%h expected 00000055/00000055", da, db);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    tick();
    in_addr = 32'h20; in_data = 32'h12345678; in_strb = 4'hF; in_valid = 1'b1;
    out_addr = {32'h20, 32'h0C}; out_valid = 2'b11;
    tick();
    checks++;
    if ({in_ready, out_ready} !== 3'b100) begin
      errors++;
      $display("FAIL contend_c1: got %b expected 100", {in_ready, out_ready});
    end
    mdl[8] = 32'h12345678;
    in_valid = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_ready} !== 3'b001 || out_data[31:0] !== mdl[3]) begin
      errors++;
      $display("FAIL contend_c2: got %b data=%h expected 001/%h", {in_ready, out_ready}, out_data[31:0], mdl[3]);
    end
    out_valid[0] = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_ready} !== 3'b010 || out_data[63:32] !== 32'h12345678) begin
      errors++;
      $display("FAIL contend_c3: got %b data=%h expected 010/12345678", {in_ready, out_ready}, out_data[63:32]);
    end
    out_valid = '0;
    tick();
    checks++;
    if ({in_ready, out_ready} !== 3'b000) begin
      errors++;
      $display("FAIL contend_c4: got %b expected 000", {in_ready, out_ready});
    end
  endtask

  task automatic test_streaming();
    logic [1:0]  exp_r;
    logic [31:0] exp_d;
    pulse_reset();
    tick();
    out_addr = {32'h2C, 32'h04}; out_valid = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_r = (k % 2 == 1) ? 2'b01 : 2'b10;
      exp_d = (k % 2 == 1) ? mdl[1] : mdl[11];
      checks++;
      if (out_ready !== exp_r || out_data[32*(k%2==1 ? 0 : 1) +: 32] !== exp_d) begin
        errors++;
        $display("FAIL stream_cycle%0d: got ready=%b data=%h expected %b/%h", k, out_ready,
                 out_data[32*(k%2==1 ? 0 : 1) +: 32], exp_r, exp_d);
      end
    end
    out_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    bit              wr_act;
    logic [31:0]     wa, wd;
    logic [3:0]      ws;
    bit [NRP-1:0]    ra;
    logic [31:0]     raddr [NRP];
    bit              wr_e, exp_w, found;
    bit [NRP-1:0]    rd_e, exp_r;
    int              ptr, g, p;
    pulse_reset();
    tick();
    ptr = NRP-1;
    wr_act = 1'b0; ra = '0; wa = '0; wd = '0; ws = '0;
    for (int i = 0; i < NRP; i++) raddr[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      wr_e = wr_act && !in_ready;
      for (int i = 0; i < NRP; i++) rd_e[i] = ra[i] && !out_ready[i];
      exp_w = wr_e; exp_r = '0; found = 1'b0; g = 0;
      if (!wr_e) begin
`ifdef MEMORY_MULTI_PORT_ROUND_ROBIN_EN
        for (int k = 1; k <= NRP; k++) begin
          p = (ptr + k) % NRP;
          if (!found && rd_e[p]) begin found = 1'b1; g = p; end
        end
`else
        for (int k = 0; k < NRP; k++)
          if (!found && rd_e[k]) begin found = 1'b1; g = k; end
`endif
        if (found) exp_r[g] = 1'b1;
      end
      tick();
      checks++;
      if ({in_ready, out_ready} !== {exp_w, exp_r}) begin
        errors++;
        $display("FAIL rand_grant cyc%0d: got %b expected %b", cyc, {in_ready, out_ready}, {exp_w, exp_r});
      end
      if (found) begin
        checks++;
        if (out_data[32*g +: 32] !== mdl[widx(raddr[g])]) begin
          errors++;
          $display("FAIL rand_data cyc%0d port%0d: got %h expected %h", cyc, g,
                   out_data[32*g +: 32], mdl[widx(raddr[g])]);
        end
        ptr = g;
        ra[g] = 1'b0;
      end
      if (exp_w) begin
        mdl[widx(wa)] = merge(mdl[widx(wa)], wd, ws);
        wr_act = 1'b0;
      end
      if (!wr_act && $urandom_range(0, 3) == 0) begin
        wr_act = 1'b1; wa = $urandom; wd = $urandom; ws = 4'($urandom);
      end
      for (int i = 0; i < NRP; i++)
        if (!ra[i] && $urandom_range(0, 1) == 1) begin
          ra[i] = 1'b1; raddr[i] = $urandom;
        end
      in_valid = wr_act; in_addr = wa; in_data = wd; in_strb = ws;
      for (int i = 0; i < NRP; i++) out_addr[32*i +: 32] = raddr[i];
      out_valid = ra;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    init_mem();
    test_write_read();
    test_strobe();
    test_alias();
    test_contention();
    test_streaming();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
